// File: rtl/sparc_mem_pkg.sv
// Shared opcodes, FSM encoding and access-size helpers for the SPARC RAM arbiter.
package sparc_mem_pkg;

  localparam int unsigned OPC_W = 6;
  localparam int unsigned CNT_W = 8;

  localparam logic [OPC_W-1:0] LDSB = 6'b001001;
  localparam logic [OPC_W-1:0] LDSH = 6'b001010;
  localparam logic [OPC_W-1:0] LD   = 6'b001000;
  localparam logic [OPC_W-1:0] LDUB = 6'b000001;
  localparam logic [OPC_W-1:0] LDUH = 6'b000010;
  localparam logic [OPC_W-1:0] LDD  = 6'b000011;
  localparam logic [OPC_W-1:0] STB  = 6'b000101;
  localparam logic [OPC_W-1:0] STH  = 6'b000110;
  localparam logic [OPC_W-1:0] ST   = 6'b000100;
  localparam logic [OPC_W-1:0] STD  = 6'b000111;

  localparam logic GNT_FETCH = 1'b0;
  localparam logic GNT_DATA  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RELEASE = 3'd3,
    S_SECOND  = 3'd4,
    S_DONE    = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    SZ_BYTE  = 3'd0,
    SZ_HALF  = 3'd1,
    SZ_WORD  = 3'd2,
    SZ_DWORD = 3'd3,
    SZ_BAD   = 3'd4
  } size_e;

  function automatic size_e op_size(input logic [OPC_W-1:0] op);
    case (op)
      LDSB, LDUB, STB: return SZ_BYTE;
      LDSH, LDUH, STH: return SZ_HALF;
      LD, ST:          return SZ_WORD;
      LDD, STD:        return SZ_DWORD;
      default:         return SZ_BAD;
    endcase
  endfunction

  // All legal store opcodes have op3[2] set; no legal load does.
  function automatic logic is_store(input logic [OPC_W-1:0] op);
    return op[2];
  endfunction

  function automatic logic misaligned(input size_e sz, input logic [2:0] a);
    case (sz)
      SZ_HALF:  return a[0];
      SZ_WORD:  return |a[1:0];
      SZ_DWORD: return |a;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mfc_sync.sv
// Two-flop synchronizer for the RAM's asynchronous MFC completion signal.
module mfc_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter and MFA/MFC sequencer for the 256-byte SPARC RAM.
// Define MEM_ARB_DWORD_EN to split ldd/std into two word accesses.
module mem_arbiter
  import sparc_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_ack,
  output logic                  if_err,
  output logic [DATA_W-1:0]     if_rdata,
  input  logic                  d_req,
  input  logic [5:0]            d_opcode,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [2*DATA_W-1:0]   d_wdata,
  output logic                  d_ack,
  output logic                  d_err,
  output logic [2*DATA_W-1:0]   d_rdata,
  output logic                  mem_mfa,
  output logic [5:0]            mem_opcode,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_mfc,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
`ifdef MEM_ARB_DWORD_EN
  localparam logic DWORD_OK = 1'b1;
`else
  localparam logic DWORD_OK = 1'b0;
`endif

  logic mfc_s;

  mfc_sync u_mfc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (mem_mfc),
    .q     (mfc_s)
  );

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  last_grant_q, last_grant_d;
  logic [OPC_W-1:0]      op_q, op_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2*DATA_W-1:0]   wdata_q, wdata_d;
  logic                  dw_q, dw_d;
  logic                  half_q, half_d;
  logic                  tmo_q, tmo_d;
  logic                  err_q, err_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   buf_q, buf_d;
  logic                  mfa_q, mfa_d;
  logic [OPC_W-1:0]      mem_opcode_q, mem_opcode_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  if_ack_q, if_ack_d, if_err_q, if_err_d;
  logic                  d_ack_q, d_ack_d, d_err_q, d_err_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
  logic [2*DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                  busy_q, busy_d;
  size_e                 sz_c;

  assign sz_c = op_size(op_q);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    dw_d         = dw_q;
    half_d       = half_q;
    tmo_d        = tmo_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    buf_d        = buf_q;
    mfa_d        = mfa_q;
    mem_opcode_d = mem_opcode_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_ack_d     = 1'b0;
    if_err_d     = 1'b0;
    d_ack_d      = 1'b0;
    d_err_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          // On conflict the port not served last wins.
          grant_d = (if_req && d_req) ? ~last_grant_q : (d_req ? GNT_DATA : GNT_FETCH);
          if (grant_d == GNT_DATA) begin
            op_d    = d_opcode;
            addr_d  = d_addr;
            wdata_d = d_wdata;
          end else begin
            op_d    = LD;
            addr_d  = if_addr;
            wdata_d = '0;
          end
          dw_d    = 1'b0;
          half_d  = 1'b0;
          tmo_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sz_c == SZ_BAD || (sz_c == SZ_DWORD && !DWORD_OK) || misaligned(sz_c, addr_q[2:0])) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          dw_d         = (sz_c == SZ_DWORD);
          mfa_d        = 1'b1;
          mem_addr_d   = addr_q;
          mem_opcode_d = dw_d ? (is_store(op_q) ? ST : LD) : op_q;
          mem_wdata_d  = dw_d ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
          state_d      = S_ISSUE;
        end
      end
`ifdef MEM_ARB_DWORD_EN
      S_ISSUE, S_SECOND: begin
`else
      S_ISSUE: begin
`endif
        if (mfc_s) begin
          if (!is_store(op_q)) begin
            if (!dw_q)       buf_d = {{DATA_W{1'b0}}, mem_rdata};
            else if (half_q) buf_d[DATA_W-1:0] = mem_rdata;
            else             buf_d[2*DATA_W-1:DATA_W] = mem_rdata;
          end
          mfa_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else if (cnt_q == TMO_LAST) begin
          mfa_d   = 1'b0;
          tmo_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // After a timeout, give MFC a full window to settle before reporting.
        if (tmo_q || mfc_s) begin
          if (cnt_q == TMO_LAST) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = S_DONE;
`ifdef MEM_ARB_DWORD_EN
          if (dw_q && !half_q) begin
            half_d      = 1'b1;
            mfa_d       = 1'b1;
            mem_addr_d  = addr_q + ADDR_W'(4);
            mem_wdata_d = wdata_q[DATA_W-1:0];
            state_d     = S_SECOND;
          end
`endif
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Completion pulse and load-data commit happen on entry to DONE.
    if (state_d == S_DONE) begin
      if_ack_d = (grant_q == GNT_FETCH);
      d_ack_d  = (grant_q == GNT_DATA);
      if_err_d = (grant_q == GNT_FETCH) && err_d;
      d_err_d  = (grant_q == GNT_DATA) && err_d;
      if (!err_d && !is_store(op_q)) begin
        if (grant_q == GNT_DATA) d_rdata_d  = buf_q;
        else                     if_rdata_d = buf_q[DATA_W-1:0];
      end
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      grant_q      <= GNT_FETCH;
      last_grant_q <= GNT_FETCH;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      dw_q         <= 1'b0;
      half_q       <= 1'b0;
      tmo_q        <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      buf_q        <= '0;
      mfa_q        <= 1'b0;
      mem_opcode_q <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      if_ack_q     <= 1'b0;
      if_err_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      d_err_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      dw_q         <= dw_d;
      half_q       <= half_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      buf_q        <= buf_d;
      mfa_q        <= mfa_d;
      mem_opcode_q <= mem_opcode_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      if_ack_q     <= if_ack_d;
      if_err_q     <= if_err_d;
      d_ack_q      <= d_ack_d;
      d_err_q      <= d_err_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      busy_q       <= busy_d;
    end
  end

  assign if_ack     = if_ack_q;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign d_ack      = d_ack_q;
  assign d_err      = d_err_q;
  assign d_rdata    = d_rdata_q;
  assign mem_mfa    = mfa_q;
  assign mem_opcode = mem_opcode_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign busy       = busy_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and sequencer for the SPARC core's 256-byte RAM. It shares the single RAM port between the instruction-fetch requester and the data (load/store) requester, and drives the RAM's MFA/MFC completion handshake from a synchronous state machine. It checks opcodes and alignment, and optionally splits ldd/std into two word accesses. It sits between the fetch/execute units and the RAM instance.

## Interface
- `ADDR_W`, 8: RAM byte-address width.
- `DATA_W`, 32: RAM data width.
- `TIMEOUT_CYC`, 16: cycles to wait for each MFC edge before aborting; legal range 4..255.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request, held until `if_ack`.
- `if_addr` in ADDR_W: fetch word address.
- `if_ack` out 1: one-cycle completion pulse.
- `if_err` out 1: valid with `if_ack`.
- `if_rdata` out DATA_W: fetched word, valid from `if_ack` until the next fetch ack.
- `d_req` in 1: data request, held until `d_ack`.
- `d_opcode` in 6: SPARC load/store opcode.
- `d_addr` in ADDR_W: data byte address.
- `d_wdata` in 2*DATA_W: store data; [31:0] used unless std.
- `d_ack` out 1: one-cycle completion pulse.
- `d_err` out 1: valid with `d_ack`.
- `d_rdata` out 2*DATA_W: load data, held until the next load ack.
- `mem_mfa` out 1: RAM access request.
- `mem_opcode` out 6: RAM opcode.
- `mem_addr` out ADDR_W: RAM address.
- `mem_wdata` out DATA_W: RAM write data.
- `mem_rdata` in DATA_W: RAM DataOut.
- `mem_mfc` in 1: RAM completion; asynchronous to `clk`.
- `busy` out 1: high in any state except IDLE.

## Operation
- **States:** IDLE, CHECK, ISSUE, RELEASE, SECOND, DONE.
- **IDLE → CHECK:**
  - If either request is high, register the grant, latch the winner's opcode, address and wdata, and go to CHECK.
  - Fetch always uses opcode 001000 (ld).
- **Arbitration:**
  - The single requester wins.
  - On a conflict, grant the port not granted last. The `last_grant` flag resets to fetch, so data wins the first conflict.
- **CHECK:**
  - Error if the opcode is outside {001001, 001010, 001000, 000001, 000010, 000011, 000101, 000110, 000100, 000111}.
  - Error if halfword access has addr[0]≠0.
  - Error if word access has addr[1:0]≠0.
  - Error if dword access has addr[2:0]≠0.
  - On error: go to DONE with err=1; no RAM access occurs.
  - Otherwise: go to ISSUE.
- **ISSUE:**
  - Drive `mem_mfa`=1 with opcode, address and wdata.
  - Wait for synchronized MFC=1.
  - For loads, capture `mem_rdata` on that cycle: non-dword loads fill d_rdata[31:0] and zero [63:32]; fetch fills `if_rdata`.
  - Then go to RELEASE.
- **RELEASE:**
  - Drive `mem_mfa`=0 and wait for synchronized MFC=0.
  - Go to SECOND if the first half of a dword is pending; otherwise go to DONE.
- **SECOND:** Reissue as ISSUE/RELEASE with addr+4 and the word opcode (see Configuration).
- **DONE:**
  - Pulse the granted port's ack and err for one cycle.
  - Update `last_grant` and return to IDLE.
  - A new request can be accepted on the next cycle.
- **Timeout:**
  - A counter runs in ISSUE, RELEASE and SECOND and is cleared on each awaited MFC edge.
  - At TIMEOUT_CYC: drop MFA, wait TIMEOUT_CYC more cycles for MFC low, then go to DONE with err=1. Load data is not updated.
- **Illegal requester behaviour:** a request dropped before ack is ignored; the transaction completes and ack still pulses.
- **Mid-operation reset:** MFA drops on that edge and state returns to IDLE. The in-flight transaction is lost and gets no ack.

## Timing
- **Reset values:** all outputs 0, including `if_rdata`/`d_rdata`; `last_grant`=fetch.
- **MFC synchronizer:** 2 flops, adding 2 cycles per edge.
- **Best-case single access:** req cycle 0 → CHECK 1 → MFA high at cycle 2. With MFC returning immediately: capture at 4, MFA low at 5, ack at 8. With the macro, a dword takes 6 more cycles.
- **Output stability:** mem_* outputs are registered and held stable for the whole time MFA is high.
- **Simultaneous events:** a request arriving in DONE is seen in the following IDLE cycle.

## Configuration
- `MEM_ARB_DWORD_EN` defined:
  - ldd (000011) issues ld at addr → d_rdata[63:32], then ld at addr+4 → d_rdata[31:0].
  - std (000111) issues st of d_wdata[63:32] at addr, then st of [31:0] at addr+4.
  - Alignment guarantees no address wrap.
- Undefined: 000011 and 000111 are treated as illegal (err, no RAM access); the SECOND state is not built.

## Structure
- **Package `sparc_mem_pkg`:**
  - Opcode localparams (LDSB, LDSH, LD, LDUB, LDUH, LDD, STB, STH, ST, STD).
  - State encoding.
  - Access-size classification function used for alignment checks.
- **Sub-module `mfc_sync`:** 2-flop synchronizer with reset-to-0, instantiated once on `mem_mfc`.

## Test plan
- **Fetch read:** RAM model stores 0xDEADBEEF at 0x10; `if_req`, addr 0x10 → `if_ack` pulse, `if_rdata`=0xDEADBEEF, `if_err`=0, ack 8 cycles after req with a zero-delay model.
- **Conflict:** `if_req` and `d_req` (ldub 0x03) in the same cycle → data acked first, then fetch; a second simultaneous pair → fetch first.
- **Error checks:**
  - st at 0x02 → `d_err`=1, `mem_mfa` never asserted.
  - opcode 0x3F → `d_err`=1.
  - sth at 0x04 → ok.
- **Dword (with macro):** std 0x1122334455667788 at 0x20, then ldd 0x20 → `d_rdata`=0x1122334455667788; two MFA pulses each. Without macro → `d_err`=1.
- **Timeout and reset:**
  - MFC held low → `mem_mfa` drops after 16 cycles, then `d_ack`+`d_err` after a further 16.
  - `rst_n` low during ISSUE → `mem_mfa`=0 next edge, no ack, `busy`=0.
